// File: rtl/ioctl_tx.sv
// rtl/ioctl_tx.sv - ioctl ROM-download transmitter, paced writes from a byte stream
// Optional running checksum built only when IOCTL_TX_CHECKSUM_EN is defined.
module ioctl_tx #(
    parameter int ADDR_W      = 25,
    parameter int WR_GAP      = 2,
    parameter int TAIL_CYCLES = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic              abort,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ioctl_download,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic              busy,
    output logic              done,
    output logic [7:0]        checksum
);

    localparam logic [7:0] GAP_LOAD  = 8'(WR_GAP - 1);
    localparam logic [7:0] TAIL_LOAD = 8'(TAIL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FETCH,
        S_WRITE,
        S_GAP,
        S_TAIL
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] ioctl_addr_q, ioctl_addr_d;
    logic [7:0]        dout_q, dout_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              done_q, done_d;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rem_q        <= '0;
            addr_q       <= '0;
            ioctl_addr_q <= '0;
            dout_q       <= 8'h00;
            cnt_q        <= 8'h00;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            addr_q       <= addr_d;
            ioctl_addr_q <= ioctl_addr_d;
            dout_q       <= dout_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        addr_d       = addr_q;
        ioctl_addr_d = ioctl_addr_q;
        dout_d       = dout_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ARM;
                    rem_d   = len;
                    addr_d  = '0;
                end
            end
            S_ARM: begin
                if (rem_q == '0) begin
                    state_d = S_TAIL;
                    cnt_d   = TAIL_LOAD;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Abort suppresses the handshake so no byte is consumed on the way out.
                if (s_valid && !abort) begin
                    state_d      = S_WRITE;
                    dout_d       = s_data;
                    ioctl_addr_d = addr_q;
                end
            end
            S_WRITE: begin
                addr_d = addr_q + ADDR_W'(1);
                rem_d  = rem_q - ADDR_W'(1);
                if (rem_q == ADDR_W'(1)) begin
                    state_d = S_TAIL;
                    cnt_d   = TAIL_LOAD;
                end else if (WR_GAP == 0) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (cnt_q == 8'h00) state_d = S_FETCH;
                else                cnt_d   = cnt_q - 8'd1;
            end
            S_TAIL: begin
                if (cnt_q == 8'h00) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        s_ready        = (state_q == S_FETCH) && !abort;
        ioctl_download = (state_q != S_IDLE);
        busy           = (state_q != S_IDLE);
        ioctl_wr       = (state_q == S_WRITE);
        ioctl_addr     = ioctl_addr_q;
        ioctl_dout     = dout_q;
        done           = done_q;
    end

`ifdef IOCTL_TX_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == S_IDLE && start) csum_d = 8'h00;
        else if (state_q == S_WRITE)    csum_d = csum_q + dout_q;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) csum_q <= 8'h00;
        else       csum_q <= csum_d;
    end

    assign checksum = csum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule
